// File: rtl/fetch_aligner.sv
// Fetch-side realigner: splits word-aligned fetch words into a halfword queue and emits one
// instruction per handshake. Define FETCH_ALIGN_RVC_EN for RVC support; otherwise RV32I-only.
module fetch_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic [31:0] fetch_addr,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic [31:0] fetch_data,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] ins,
  output logic [31:0] ins_pc,
  output logic        ins_comp
);

`ifdef FETCH_ALIGN_RVC_EN
  localparam logic        RVC_EN   = 1'b1;
  localparam int          QDEPTH   = 3;
  localparam logic [1:0]  PUSH_MAX = 2'd1;
  localparam logic [31:0] PC_MASK  = 32'hFFFF_FFFE;
`else
  localparam logic        RVC_EN   = 1'b0;
  localparam int          QDEPTH   = 2;
  localparam logic [1:0]  PUSH_MAX = 2'd0;
  localparam logic [31:0] PC_MASK  = 32'hFFFF_FFFC;
`endif

  function automatic logic is_rvc(input logic [15:0] hw);
    return hw[1:0] != 2'b11;
  endfunction

  logic [QDEPTH-1:0][15:0] q_r;
  logic [QDEPTH-1:0][15:0] q_sh_s;
  logic [QDEPTH-1:0][15:0] q_nxt_s;
  logic [1:0]              cnt_r;
  logic [31:0]             hpc_r;
  logic [31:0]             faddr_r;
  logic                    drop_r;

  logic                    head_comp_s;
  logic                    ins_valid_s;
  logic                    pop_s;
  logic [1:0]              pop_amt_s;
  logic [1:0]              left_s;
  logic                    fetch_ready_s;
  logic                    push_s;

  // Head decode, pop size and push admission (pop is resolved before push)
  always_comb begin
    head_comp_s = RVC_EN && is_rvc(q_r[0]);
    if (flush) begin
      ins_valid_s = 1'b0;
    end else if (head_comp_s) begin
      ins_valid_s = (cnt_r >= 2'd1);
    end else begin
      ins_valid_s = (cnt_r >= 2'd2);
    end
    pop_s = ins_valid_s && ins_ready;
    if (!pop_s) begin
      pop_amt_s = 2'd0;
    end else if (head_comp_s) begin
      pop_amt_s = 2'd1;
    end else begin
      pop_amt_s = 2'd2;
    end
    left_s        = cnt_r - pop_amt_s;
    fetch_ready_s = !flush && (left_s <= PUSH_MAX);
    push_s        = fetch_valid && fetch_ready_s;
  end

  // Next queue: shift out popped halfwords, then append the accepted word behind the survivors
  always_comb begin
    q_sh_s = q_r >> {pop_amt_s, 4'd0};
    for (int i = 0; i < QDEPTH; i++) begin
      if (push_s && (2'(i) == left_s)) begin
        q_nxt_s[i] = drop_r ? fetch_data[31:16] : fetch_data[15:0];
      end else if (push_s && !drop_r && (2'(i) == (left_s + 2'd1))) begin
        q_nxt_s[i] = fetch_data[31:16];
      end else begin
        q_nxt_s[i] = q_sh_s[i];
      end
    end
  end

  // Queue, head pc, fetch address and drop flag; a redirect overrides any handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r     <= {QDEPTH{16'h0000}};
      cnt_r   <= 2'd0;
      hpc_r   <= RESET_PC & PC_MASK;
      faddr_r <= {RESET_PC[31:2], 2'b00};
      drop_r  <= RVC_EN & RESET_PC[1];
    end else if (flush) begin
      cnt_r   <= 2'd0;
      hpc_r   <= flush_pc & PC_MASK;
      faddr_r <= {flush_pc[31:2], 2'b00};
      drop_r  <= RVC_EN & flush_pc[1];
    end else begin
      q_r   <= q_nxt_s;
      cnt_r <= left_s + (push_s ? (drop_r ? 2'd1 : 2'd2) : 2'd0);
      if (pop_s) begin
        hpc_r <= hpc_r + (head_comp_s ? 32'd2 : 32'd4);
      end
      if (push_s) begin
        faddr_r <= faddr_r + 32'd4;
        drop_r  <= 1'b0;
      end
    end
  end

  assign fetch_addr  = faddr_r;
  assign fetch_ready = fetch_ready_s;
  assign ins_valid   = ins_valid_s;
  assign ins_pc      = hpc_r;
  assign ins_comp    = (cnt_r != 2'd0) && head_comp_s;
  assign ins         = (cnt_r == 2'd0) ? 32'h0000_0000 :
                       head_comp_s     ? {16'h0000, q_r[0]} : {q_r[1], q_r[0]};

endmodule

// File: tb/tb_fetch_aligner.sv
// Directed bench for fetch_aligner; exercises whichever configuration the RTL is built in
// (FETCH_ALIGN_RVC_EN defined or not).
module tb_fetch_aligner;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [31:0] flush_pc;
  logic [31:0] fetch_addr;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_data;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins;
  logic [31:0] ins_pc;
  logic        ins_comp;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_aligner #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .flush_pc(flush_pc),
    .fetch_addr(fetch_addr), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_data(fetch_data), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .ins(ins), .ins_pc(ins_pc), .ins_comp(ins_comp)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_ins(input string tag, input logic v, input logic [31:0] i,
                            input logic [31:0] pc, input logic c);
    check_eq({tag, ".valid"}, 32'(ins_valid), 32'(v));
    if (v) begin
      check_eq({tag, ".ins"},  ins, i);
      check_eq({tag, ".pc"},   ins_pc, pc);
      check_eq({tag, ".comp"}, 32'(ins_comp), 32'(c));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0; flush_pc = 32'h0; fetch_valid = 1'b0;
    fetch_data = 32'h0; ins_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  // Offer one word, expect it to be taken this cycle, then idle the fetch side
  task automatic push_word(input string tag, input logic [31:0] w);
    fetch_valid = 1'b1;
    fetch_data  = w;
    #1;
    check_eq({tag, ".fready"}, 32'(fetch_ready), 32'd1);
    tick();
    fetch_valid = 1'b0;
    #1;
  endtask

  task automatic reset_checks();
    check_eq("rst.valid",  32'(ins_valid), 32'd0);
    check_eq("rst.fready", 32'(fetch_ready), 32'd1);
    check_eq("rst.ins",    ins, 32'h0);
    check_eq("rst.comp",   32'(ins_comp), 32'd0);
    check_eq("rst.faddr",  fetch_addr, 32'h0);
    check_eq("rst.pc",     ins_pc, 32'h0);
  endtask

  task automatic async_reset_check(input string tag);
    #2 rst_n = 1'b0;
    #1;
    check_eq({tag, ".valid"}, 32'(ins_valid), 32'd0);
    check_eq({tag, ".faddr"}, fetch_addr, 32'h0);
    check_eq({tag, ".fready"}, 32'(fetch_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    #1;
    check_eq({tag, ".faddr2"}, fetch_addr, 32'h0);
    check_eq({tag, ".valid2"}, 32'(ins_valid), 32'd0);
  endtask

  initial begin
    do_reset();
    reset_checks();

`ifdef FETCH_ALIGN_RVC_EN
    // 1: single 32-bit instruction
    push_word("t1", 32'h0000_0013);
    check_eq("t1.faddr", fetch_addr, 32'h4);
    expect_ins("t1", 1'b1, 32'h0000_0013, 32'h0, 1'b0);

    // 2: two RVC halfwords in one word
    do_reset();
    ins_ready = 1'b1;
    push_word("t2", 32'h4501_0505);
    expect_ins("t2a", 1'b1, 32'h0000_0505, 32'h0, 1'b1);
    tick();
    expect_ins("t2b", 1'b1, 32'h0000_4501, 32'h2, 1'b1);
    tick();
    expect_ins("t2e", 1'b0, 32'h0, 32'h0, 1'b0);

    // 3: straddling 32-bit instruction with a delayed second word
    do_reset();
    ins_ready = 1'b1;
    push_word("t3w1", 32'h0413_4501);
    expect_ins("t3a", 1'b1, 32'h0000_4501, 32'h0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_ins("t3gap", 1'b0, 32'h0, 32'h0, 1'b0);
    end
    push_word("t3w2", 32'h4505_0631);
    expect_ins("t3b", 1'b1, 32'h0631_0413, 32'h2, 1'b0);
    tick();
    expect_ins("t3c", 1'b1, 32'h0000_4505, 32'h6, 1'b1);

    // 4: flush to a halfword target while data is buffered
    do_reset();
    push_word("t4w0", 32'h0000_0013);
    flush = 1'b1; flush_pc = 32'h0000_0102; fetch_valid = 1'b1; fetch_data = 32'hFFFF_FFFF;
    #1;
    check_eq("t4.fl_valid", 32'(ins_valid), 32'd0);
    check_eq("t4.fl_fready", 32'(fetch_ready), 32'd0);
    tick();
    flush = 1'b0; fetch_valid = 1'b0;
    #1;
    check_eq("t4.faddr", fetch_addr, 32'h100);
    check_eq("t4.empty", 32'(ins_valid), 32'd0);
    ins_ready = 1'b1;
    push_word("t4w1", 32'h0001_0505);
    expect_ins("t4", 1'b1, 32'h0000_0001, 32'h102, 1'b1);
    check_eq("t4.faddr2", fetch_addr, 32'h104);
    tick();
    expect_ins("t4.nolow", 1'b0, 32'h0, 32'h0, 1'b0);

    // 5: full queue under backpressure, then drain
    do_reset();
    ins_ready = 1'b1;
    push_word("t5w1", 32'h0413_4501);
    tick();
    ins_ready = 1'b0;
    push_word("t5w2", 32'h4505_0631);
    for (int k = 0; k < 5; k++) begin
      expect_ins("t5hold", 1'b1, 32'h0631_0413, 32'h2, 1'b0);
      check_eq("t5.fready_hold", 32'(fetch_ready), 32'd0);
      tick();
    end
    ins_ready = 1'b1;
    #1;
    check_eq("t5.fready_pop", 32'(fetch_ready), 32'd1);
    tick();
    expect_ins("t5d", 1'b1, 32'h0000_4505, 32'h6, 1'b1);
    check_eq("t5.fready_last", 32'(fetch_ready), 32'd1);
    tick();
    expect_ins("t5e", 1'b0, 32'h0, 32'h0, 1'b0);

    // 6: asynchronous reset mid-stream with two halfwords buffered
    do_reset();
    push_word("t6", 32'h4501_0505);
    expect_ins("t6pre", 1'b1, 32'h0000_0505, 32'h0, 1'b1);
    async_reset_check("t6");
`else
    // RV32I: first word, latency and full-queue behaviour
    fetch_valid = 1'b1; fetch_data = 32'h0000_0013;
    #1;
    check_eq("t1.fready", 32'(fetch_ready), 32'd1);
    check_eq("t1.lat", 32'(ins_valid), 32'd0);
    tick();
    fetch_valid = 1'b0;
    #1;
    check_eq("t1.faddr", fetch_addr, 32'h4);
    expect_ins("t1", 1'b1, 32'h0000_0013, 32'h0, 1'b0);
    check_eq("t1.fready_full", 32'(fetch_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_ins("bp", 1'b1, 32'h0000_0013, 32'h0, 1'b0);
    end
    check_eq("bp.faddr", fetch_addr, 32'h4);
    ins_ready = 1'b1;
    #1;
    check_eq("t1.fready_pop", 32'(fetch_ready), 32'd1);
    tick();
    expect_ins("t1.empty", 1'b0, 32'h0, 32'h0, 1'b0);
    check_eq("t1.empty_ins", ins, 32'h0);

    // Back-to-back words while draining
    fetch_valid = 1'b1; fetch_data = 32'hA1B2_C3D7;
    tick();
    fetch_data = 32'h1122_3347;
    #1;
    check_eq("s.fready", 32'(fetch_ready), 32'd1);
    expect_ins("s1", 1'b1, 32'hA1B2_C3D7, 32'h4, 1'b0);
    tick();
    fetch_valid = 1'b0;
    #1;
    expect_ins("s2", 1'b1, 32'h1122_3347, 32'h8, 1'b0);
    check_eq("s.faddr", fetch_addr, 32'hC);
    tick();
    expect_ins("s.empty", 1'b0, 32'h0, 32'h0, 1'b0);

    // Flush with buffered data and a coincident fetch; pc[1] of the target is ignored
    ins_ready = 1'b0;
    push_word("flw0", 32'h00A0_0093);
    flush = 1'b1; flush_pc = 32'h0000_0102; fetch_valid = 1'b1; fetch_data = 32'hDEAD_BEEF;
    #1;
    check_eq("fl.valid", 32'(ins_valid), 32'd0);
    check_eq("fl.fready", 32'(fetch_ready), 32'd0);
    tick();
    flush = 1'b0; fetch_valid = 1'b0;
    #1;
    check_eq("fl.faddr", fetch_addr, 32'h100);
    check_eq("fl.empty", 32'(ins_valid), 32'd0);
    ins_ready = 1'b1;
    push_word("flw1", 32'h1234_5678);
    expect_ins("fl", 1'b1, 32'h1234_5678, 32'h100, 1'b0);

    // Address wrap at the top of memory
    tick();
    flush = 1'b1; flush_pc = 32'hFFFF_FFFC;
    tick();
    flush = 1'b0;
    #1;
    check_eq("wr.faddr", fetch_addr, 32'hFFFF_FFFC);
    push_word("wrw0", 32'h0000_0013);
    expect_ins("wr0", 1'b1, 32'h0000_0013, 32'hFFFF_FFFC, 1'b0);
    check_eq("wr.faddr2", fetch_addr, 32'h0);
    tick();
    push_word("wrw1", 32'h0010_0073);
    expect_ins("wr1", 1'b1, 32'h0010_0073, 32'h0, 1'b0);

    // Asynchronous reset mid-stream
    ins_ready = 1'b0;
    tick();
    async_reset_check("ar");
    ins_ready = 1'b0;
    push_word("arw", 32'h0000_0013);
    expect_ins("ar.after", 1'b1, 32'h0000_0013, 32'h0, 1'b0);
    async_reset_check("ar2");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
